// File: rtl/fpga_ahb_pkg.sv
// Shared constants for the FPGA AHB register slave: register map indices,
// out-of-window read value and bus FSM state encoding.
package fpga_ahb_pkg;

    localparam int NUM_CFG = 8;

    localparam logic [3:0] REG_ID      = 4'd0;
    localparam logic [3:0] REG_SCRATCH = 4'd1;
    localparam logic [3:0] REG_IRQ_STS = 4'd2;
    localparam logic [3:0] REG_IRQ_EN  = 4'd3;
    localparam logic [3:0] REG_CFG0    = 4'd4;
    localparam logic [3:0] REG_CFG1    = 4'd5;
    localparam logic [3:0] REG_CFG2    = 4'd6;
    localparam logic [3:0] REG_CFG3    = 4'd7;
    localparam logic [3:0] REG_CFG4    = 4'd8;
    localparam logic [3:0] REG_CFG5    = 4'd9;
    localparam logic [3:0] REG_CFG6    = 4'd10;
    localparam logic [3:0] REG_CFG7    = 4'd11;
    localparam logic [3:0] REG_STS0    = 4'd12;
    localparam logic [3:0] REG_STS1    = 4'd13;
    localparam logic [3:0] REG_STS2    = 4'd14;
    localparam logic [3:0] REG_STS3    = 4'd15;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fpga_irq_ctrl.sv
// Interrupt block: per-source rising-edge detect, W1C status, enable mask
// and a registered level interrupt output.
module fpga_irq_ctrl
    import fpga_ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_src_i,
    input  logic       sts_clr,
    input  logic       en_wr,
    input  logic [7:0] wdata,
    output logic [7:0] irq_status,
    output logic [7:0] irq_enable,
    output logic       interrupt
);

    logic [7:0] src_q;
    logic [7:0] rise;
    logic [7:0] clr_mask;

    assign rise     = irq_src_i & ~src_q;
    assign clr_mask = sts_clr ? wdata : 8'h00;

    // Set is OR-ed in after the clear so a new edge wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= 8'h00;
            irq_status <= 8'h00;
            irq_enable <= 8'h00;
            interrupt  <= 1'b0;
        end else begin
            src_q      <= irq_src_i;
            irq_status <= (irq_status & ~clr_mask) | rise;
            if (en_wr) begin
                irq_enable <= wdata;
            end
            interrupt  <= |(irq_status & irq_enable);
        end
    end

endmodule

// File: rtl/fpga_ahb_reg_slave.sv
// Register slave on the FPGA AHB bus: 16-word window with ID, scratch,
// interrupt, config and status registers behind a fixed wait-state handshake.
module fpga_ahb_reg_slave
    import fpga_ahb_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR   = 14'h0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h4831_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fpga_HSEL,
    input  logic         fpga_HWRITE,
    input  logic [19:0]  fpga_HADDR,
    input  logic [31:0]  fpga_HWDATA,
    output logic [31:0]  fpga_HRDATA,
    output logic         fpga_HREADY,
    input  logic [127:0] sts_i,
    input  logic [7:0]   irq_src_i,
    output logic [255:0] cfg_o,
    output logic         interrupt
);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [17:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        hready_q;
    logic [31:0] rdata_q;
    logic [31:0] scratch_q;
    logic [31:0] cfg_q [NUM_CFG];
    logic [7:0]  irq_status;
    logic [7:0]  irq_enable;
    logic        irq_line;

    logic [3:0]  reg_idx;
    logic        in_window;
    logic        ack_edge;
    logic        wr_commit;
    logic [31:0] rd_word;
    logic        unused_addr_lsbs;

    assign reg_idx          = addr_q[3:0];
    assign in_window        = (addr_q[17:4] == BASE_ADDR);
    assign ack_edge         = (state == ST_WAIT) && (wait_cnt == 4'd0);
    assign wr_commit        = ack_edge && write_q && in_window;
    assign unused_addr_lsbs = ^fpga_HADDR[1:0];

    // Bus handshake: accept in IDLE, count wait states, one-cycle ACK,
    // then park in DONE until the master drops HSEL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            hready_q <= 1'b0;
        end else begin
            hready_q <= ack_edge;
            case (state)
                ST_IDLE: begin
                    if (fpga_HSEL) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 4'(WAIT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_DONE;
                end
                default: begin
                    if (!fpga_HSEL) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Request is captured once at acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && fpga_HSEL) begin
            addr_q  <= fpga_HADDR[19:2];
            write_q <= fpga_HWRITE;
            wdata_q <= fpga_HWDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (ack_edge && !write_q) begin
            rdata_q <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= 32'h0;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= 32'h0;
            end
        end else if (wr_commit) begin
            if (reg_idx == REG_SCRATCH) begin
                scratch_q <= wdata_q;
            end
            for (int i = 0; i < NUM_CFG; i++) begin
                if (reg_idx == (REG_CFG0 + 4'(i))) begin
                    cfg_q[i] <= wdata_q;
                end
            end
        end
    end

    always_comb begin
        rd_word = 32'h0;
        if (!in_window) begin
            rd_word = DEAD_BEEF;
        end else begin
            case (reg_idx)
                REG_ID:      rd_word = ID_VALUE;
                REG_SCRATCH: rd_word = scratch_q;
                REG_IRQ_STS: rd_word = {24'h0, irq_status};
                REG_IRQ_EN:  rd_word = {24'h0, irq_enable};
                REG_CFG0:    rd_word = cfg_q[0];
                REG_CFG1:    rd_word = cfg_q[1];
                REG_CFG2:    rd_word = cfg_q[2];
                REG_CFG3:    rd_word = cfg_q[3];
                REG_CFG4:    rd_word = cfg_q[4];
                REG_CFG5:    rd_word = cfg_q[5];
                REG_CFG6:    rd_word = cfg_q[6];
                REG_CFG7:    rd_word = cfg_q[7];
                REG_STS0:    rd_word = sts_i[31:0];
                REG_STS1:    rd_word = sts_i[63:32];
                REG_STS2:    rd_word = sts_i[95:64];
                REG_STS3:    rd_word = sts_i[127:96];
                default:     rd_word = 32'h0;
            endcase
        end
    end

    fpga_irq_ctrl u_irq_ctrl (
        .clk        (clk),
        .rst        (rst),
        .irq_src_i  (irq_src_i),
        .sts_clr    (wr_commit && (reg_idx == REG_IRQ_STS)),
        .en_wr      (wr_commit && (reg_idx == REG_IRQ_EN)),
        .wdata      (wdata_q[7:0]),
        .irq_status (irq_status),
        .irq_enable (irq_enable),
        .interrupt  (irq_line)
    );

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_o[32*g +: 32] = cfg_q[g];
    end

    assign fpga_HRDATA = rdata_q;
    assign fpga_HREADY = hready_q;
    assign interrupt   = irq_line;

endmodule

// File: tb/tb_fpga_ahb_reg_slave.sv
// Self-checking bench for fpga_ahb_reg_slave: directed vector table, handshake
// corner sequences and randomized traffic against a register-map model.
module tb_fpga_ahb_reg_slave;

    localparam int WAIT_CYC = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         fpga_HSEL;
    logic         fpga_HWRITE;
    logic [19:0]  fpga_HADDR;
    logic [31:0]  fpga_HWDATA;
    logic [31:0]  fpga_HRDATA;
    logic         fpga_HREADY;
    logic [127:0] sts_i;
    logic [7:0]   irq_src_i;
    logic [255:0] cfg_o;
    logic         interrupt;

    int n_chk  = 0;
    int n_fail = 0;

    fpga_ahb_reg_slave #(
        .BASE_ADDR   (14'h0000),
        .WAIT_CYCLES (WAIT_CYC),
        .ID_VALUE    (32'h4831_0001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fpga_HSEL   (fpga_HSEL),
        .fpga_HWRITE (fpga_HWRITE),
        .fpga_HADDR  (fpga_HADDR),
        .fpga_HWDATA (fpga_HWDATA),
        .fpga_HRDATA (fpga_HRDATA),
        .fpga_HREADY (fpga_HREADY),
        .sts_i       (sts_i),
        .irq_src_i   (irq_src_i),
        .cfg_o       (cfg_o),
        .interrupt   (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;   // read: HRDATA; write: cfg_o[31:0] afterwards
    } vec_t;

    vec_t vecs[$];

    // Register-map model
    logic [31:0] m_scratch;
    logic [31:0] m_cfg [8];
    logic [7:0]  m_sts, m_en, m_prev;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_scratch = 32'h0;
        for (int i = 0; i < 8; i++) m_cfg[i] = 32'h0;
        m_sts  = 8'h0;
        m_en   = 8'h0;
        m_prev = 8'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [19:0] a);
        int idx;
        idx = int'(a[5:2]);
        if (a[19:6] != 14'h0) return 32'hDEAD_BEEF;
        if (idx == 0) return 32'h4831_0001;
        if (idx == 1) return m_scratch;
        if (idx == 2) return {24'h0, m_sts};
        if (idx == 3) return {24'h0, m_en};
        if (idx <= 11) return m_cfg[idx - 4];
        return sts_i[32*(idx - 12) +: 32];
    endfunction

    task automatic model_write(input logic [19:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a[5:2]);
        if (a[19:6] == 14'h0) begin
            if (idx == 1) m_scratch = d;
            else if (idx == 2) m_sts = m_sts & ~d[7:0];
            else if (idx == 3) m_en = d[7:0];
            else if (idx >= 4 && idx <= 11) m_cfg[idx - 4] = d;
        end
    endtask

    function automatic logic [255:0] model_cfg();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = m_cfg[i];
        return v;
    endfunction

    task automatic set_src(input logic [7:0] v);
        irq_src_i = v;
        m_sts     = m_sts | (v & ~m_prev);
        m_prev    = v;
    endtask

    task automatic apply_reset();
        fpga_HSEL = 1'b0;
        irq_src_i = 8'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One complete access; bus address/direction are scrambled after acceptance.
    task automatic bus_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int lat;
        fpga_HSEL   = 1'b1;
        fpga_HWRITE = wr;
        fpga_HADDR  = addr;
        fpga_HWDATA = wdata;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                fpga_HADDR  = 20'($urandom);
                fpga_HWRITE = ~wr;
            end
        end while (!fpga_HREADY && lat < 40);
        check("latency", 256'(lat), 256'(WAIT_CYC + 2));
        rdata = fpga_HRDATA;
        fpga_HSEL = 1'b0;
        @(posedge clk);
        #1;
        check("hready_single", 256'(fpga_HREADY), 256'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, last_rd, exp_rd;
        int pulses;
        int lat;

        fpga_HSEL   = 1'b0;
        fpga_HWRITE = 1'b0;
        fpga_HADDR  = 20'h0;
        fpga_HWDATA = 32'h0;
        irq_src_i   = 8'h0;
        sts_i       = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0000};
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_hready", 256'(fpga_HREADY), 256'(0));
        check("rst_hrdata", 256'(fpga_HRDATA), 256'(0));
        check("rst_irq", 256'(interrupt), 256'(0));
        check("rst_cfg", cfg_o, 256'(0));

        vecs.push_back('{1'b0, 20'h00004, 32'h0,         32'h0000_0000});
        vecs.push_back('{1'b1, 20'h00010, 32'h1234_5678, 32'h1234_5678});
        vecs.push_back('{1'b0, 20'h00000, 32'h0,         32'h4831_0001});
        vecs.push_back('{1'b1, 20'h00004, 32'hA5A5_0F0F, 32'h1234_5678});
        vecs.push_back('{1'b0, 20'h00004, 32'h0,         32'hA5A5_0F0F});
        vecs.push_back('{1'b0, 20'h00040, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 20'h00044, 32'hFFFF_FFFF, 32'h1234_5678});
        vecs.push_back('{1'b1, 20'h00050, 32'hFFFF_FFFF, 32'h1234_5678});
        vecs.push_back('{1'b0, 20'h00004, 32'h0,         32'hA5A5_0F0F});
        vecs.push_back('{1'b1, 20'h00000, 32'h0,         32'h1234_5678});
        vecs.push_back('{1'b0, 20'h00000, 32'h0,         32'h4831_0001});
        vecs.push_back('{1'b1, 20'h0002C, 32'h0BAD_F00D, 32'h1234_5678});
        vecs.push_back('{1'b0, 20'h0002C, 32'h0,         32'h0BAD_F00D});
        vecs.push_back('{1'b1, 20'h0000C, 32'hFFFF_FFFF, 32'h1234_5678});
        vecs.push_back('{1'b0, 20'h0000C, 32'h0,         32'h0000_00FF});
        vecs.push_back('{1'b1, 20'h0000C, 32'h0,         32'h1234_5678});
        vecs.push_back('{1'b0, 20'h0000C, 32'h0,         32'h0000_0000});
        vecs.push_back('{1'b0, 20'h00030, 32'h0,         32'h0F0F_0000});
        vecs.push_back('{1'b0, 20'h0003C, 32'h0,         32'h3333_3333});

        foreach (vecs[i]) begin
            bus_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].wr) check($sformatf("vec%0d_cfg0", i), 256'(cfg_o[31:0]), 256'(vecs[i].exp));
            else            check($sformatf("vec%0d_rd", i), 256'(rd), 256'(vecs[i].exp));
        end
        check("cfg7_after_table", 256'(cfg_o[255:224]), 256'(32'h0BAD_F00D));

        // HSEL held well past the ACK with the address moved: one access only.
        fpga_HSEL   = 1'b1;
        fpga_HWRITE = 1'b1;
        fpga_HADDR  = 20'h00014;
        fpga_HWDATA = 32'hCAFE_0001;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) fpga_HADDR = 20'h00018;
            if (fpga_HREADY) pulses++;
        end
        fpga_HSEL = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_pulses", 256'(pulses), 256'(1));
        check("hold_cfg1", 256'(cfg_o[63:32]), 256'(32'hCAFE_0001));
        check("hold_cfg2", 256'(cfg_o[95:64]), 256'(0));

        // Interrupt: enable bit 0, pulse source 0.
        bus_xfer(1'b1, 20'h0000C, 32'h1, rd);
        irq_src_i = 8'h01;
        @(posedge clk);
        #1;
        check("irq_after_1", 256'(interrupt), 256'(0));
        @(posedge clk);
        #1;
        check("irq_after_2", 256'(interrupt), 256'(1));
        irq_src_i = 8'h00;
        bus_xfer(1'b1, 20'h00008, 32'h1, rd);
        check("irq_cleared", 256'(interrupt), 256'(0));
        bus_xfer(1'b0, 20'h00008, 32'h0, rd);
        check("irq_sts_cleared", 256'(rd), 256'(0));

        // W1C of bit 0 committing on the same edge as a new rising edge.
        fpga_HSEL   = 1'b1;
        fpga_HWRITE = 1'b1;
        fpga_HADDR  = 20'h00008;
        fpga_HWDATA = 32'h1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        irq_src_i = 8'h01;
        @(posedge clk);
        #1;
        check("race_ack", 256'(fpga_HREADY), 256'(1));
        fpga_HSEL = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("race_irq", 256'(interrupt), 256'(1));
        bus_xfer(1'b0, 20'h00008, 32'h0, rd);
        check("race_sts", 256'(rd), 256'(1));

        // Reset during WAIT of a write, HSEL kept high across release.
        fpga_HSEL   = 1'b1;
        fpga_HWRITE = 1'b1;
        fpga_HADDR  = 20'h00010;
        fpga_HWDATA = 32'h55AA_33CC;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_hready", 256'(fpga_HREADY), 256'(0));
        check("rstmid_cfg", cfg_o, 256'(0));
        @(posedge clk);
        #1;
        check("rstmid_nocommit", 256'(cfg_o[31:0]), 256'(0));
        check("rstmid_hready2", 256'(fpga_HREADY), 256'(0));
        lat = 1;
        while (!fpga_HREADY && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rstmid_latency", 256'(lat), 256'(WAIT_CYC + 2));
        check("rstmid_commit", 256'(cfg_o[31:0]), 256'(32'h55AA_33CC));
        fpga_HSEL = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic against the model.
        apply_reset();
        last_rd = 32'h0;
        for (int t = 0; t < 200; t++) begin
            logic        wr;
            logic [19:0] a;
            logic [31:0] d;
            logic [13:0] win;
            if ($urandom_range(0, 3) == 0) set_src(8'($urandom));
            sts_i = {$urandom, $urandom, $urandom, $urandom};
            win = ($urandom_range(0, 7) != 0) ? 14'h0 : 14'($urandom_range(1, 16383));
            a   = {win, 4'($urandom_range(0, 15)), 2'b00};
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            bus_xfer(wr, a, d, rd);
            if (wr) begin
                model_write(a, d);
                check("rnd_hold_rdata", 256'(rd), 256'(last_rd));
            end else begin
                exp_rd  = model_read(a);
                check("rnd_rdata", 256'(rd), 256'(exp_rd));
                last_rd = exp_rd;
            end
            check("rnd_cfg", cfg_o, model_cfg());
            check("rnd_irq", 256'(interrupt), 256'(|(m_sts & m_en)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_ahb_reg_slave.md
FPGA_AHB_REG_SLAVE -- requirements
Module: fpga_ahb_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 14'h0000: fpga_HADDR[19:6] value selecting this block's window.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15: wait states inserted before fpga_HREADY.
REQ-003 SHALL have parameter ID_VALUE, default 32'h4831_0001: read-only identification word.
REQ-004 SHALL have ports:
  clk  in  1  sole clock; all logic rising-edge.
  rst  in  1  synchronous, active-high reset.
  fpga_HSEL  in  1  access request, held high until fpga_HREADY seen.
  fpga_HWRITE  in  1  1 = write, 0 = read; stable while fpga_HSEL high.
  fpga_HADDR  in  20  byte address; bits [1:0] always zero.
  fpga_HWDATA  in  32  write data, stable while fpga_HSEL high.
  fpga_HRDATA  out  32  read data.
  fpga_HREADY  out  1  single-cycle completion pulse.
  sts_i  in  128  four 32-bit status words, read-only regs 12..15.
  irq_src_i  in  8  interrupt sources, rising-edge sensitive.
  cfg_o  out  256  eight 32-bit config regs 4..11, reg 4 in bits [31:0].
  interrupt  out  1  level interrupt, registered.

Function
REQ-005 SHALL decode fpga_HADDR[5:2] as register index when fpga_HADDR[19:6]==BASE_ADDR; otherwise access is out-of-window.
REQ-006 Register map SHALL be: 0 ID (RO, ID_VALUE); 1 scratch (RW); 2 irq_status (W1C); 3 irq_enable (RW, bits [7:0], upper bits read 0); 4..11 cfg (RW); 12..15 sts_i (RO, sampled at ack edge).
REQ-007 FSM SHALL have states IDLE, WAIT, ACK, DONE.
REQ-008 IDLE -> WAIT when fpga_HSEL=1, latching address, direction, write data; wait counter loaded with WAIT_CYCLES.
REQ-009 WAIT SHALL decrement counter each cycle; -> ACK when counter is 0 (WAIT_CYCLES=0: exactly one WAIT cycle).
REQ-010 ACK SHALL drive fpga_HREADY=1 for exactly one cycle, then -> DONE.
REQ-011 DONE SHALL hold fpga_HREADY=0 and -> IDLE only when fpga_HSEL=0; a still-high fpga_HSEL SHALL NOT start a second access.
REQ-012 Latency: fpga_HREADY high exactly WAIT_CYCLES+2 cycles after the edge first sampling fpga_HSEL=1.
REQ-013 Write SHALL commit on the edge entering ACK; RO regs and out-of-window writes are discarded but still acknowledged.
REQ-014 Read data SHALL be registered into fpga_HRDATA on the edge entering ACK and held until the next read ack; out-of-window reads return 32'hDEAD_BEEF.
REQ-015 irq_status[i] SHALL set on a rising edge of irq_src_i[i] (one-flop edge detector); writing 1 clears; simultaneous set and clear of same bit: set wins.
REQ-016 interrupt SHALL be registered |(irq_status & irq_enable), one cycle after status/enable change.
REQ-017 fpga_HWRITE/fpga_HADDR changes outside IDLE SHALL be ignored (values latched at acceptance).

Reset
REQ-018 On rst=1 at a clock edge: FSM=IDLE, fpga_HREADY=0, fpga_HRDATA=0, interrupt=0, scratch/irq_status/irq_enable/cfg regs=0, edge-detector flops=0, wait counter=0.
REQ-019 Reset mid-access SHALL abandon it without write commit; if fpga_HSEL is still high after reset release it SHALL be accepted as a new access.

Structure
REQ-020 Register index constants (REG_ID..REG_STS3), DEAD_BEEF constant and FSM state encoding SHALL live in shared package fpga_ahb_pkg.
REQ-021 Interrupt edge-detect/status/enable logic SHALL be sub-module fpga_irq_ctrl; decode, FSM and register file stay in top.

Verification
REQ-022 Write 32'h1234_5678 to 0x00010, WAIT_CYCLES=1 -> fpga_HREADY pulse 3 cycles after fpga_HSEL, cfg_o[31:0]=32'h1234_5678.
REQ-023 Read 0x00000 -> fpga_HRDATA=32'h4831_0001 during HREADY pulse; read 0x00004 after writing 32'hA5A5_0F0F -> 32'hA5A5_0F0F.
REQ-024 fpga_HSEL held 5 cycles after HREADY -> exactly one HREADY pulse, one register write.
REQ-025 irq_enable=0x01, pulse irq_src_i[0] -> interrupt=1 two cycles later; write 0x1 to 0x00008 same cycle as new edge -> bit stays set.
REQ-026 Read 0x00040 (BASE_ADDR=0) -> 32'hDEAD_BEEF with HREADY; write 0x00040 -> no register changes.
REQ-027 rst=1 in WAIT of write -> no commit, HREADY stays 0; fpga_HSEL held high after release -> new access acknowledged and committed.
